// File: rtl/ysyx_25020037_axi_rr_arbiter.sv
// ysyx_25020037_axi_rr_arbiter
//   Round-robin AXI4 arbiter between N_MST upstream masters (IFU, LSU, ...)
//   and two downstream targets: the io_master port (everything) and a
//   read-only local port (reads whose addr[31:16] == LOCAL_BASE, i.e. CLINT).
//   One master owns the bus for exactly one transaction (AR+R burst or
//   AW+W+B). A stall watchdog raises a sticky err_timeout flag.
// Ports
//   clk, rst                      clock, async active-high reset
//   m_{ar,r,aw,w,b}{valid,ready,_pl}  upstream channels, master i in slice i
//   io_{ar,r,aw,w,b}{valid,ready,_pl} downstream AXI4 toward the SoC
//   l_{ar,r}{valid,ready,_pl}     local read-only port
//   grant                         one-hot current owner, 0 when idle
//   err_timeout                   sticky watchdog flag
// Payload layouts: AR/AW {addr32,id4,len8,size3,burst2}, W {data32,strb4,last1},
//   R {data32,resp2,last1,id4}, B {resp2,id4}.
module ysyx_25020037_axi_rr_arbiter #(
  parameter int unsigned N_MST      = 2,
  parameter logic [15:0] LOCAL_BASE = 16'h0200,
  parameter int unsigned TIMEOUT    = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_MST-1:0]      m_arvalid,
  output logic [N_MST-1:0]      m_arready,
  input  logic [N_MST*49-1:0]   m_ar_pl,
  output logic [N_MST-1:0]      m_rvalid,
  input  logic [N_MST-1:0]      m_rready,
  output logic [N_MST*39-1:0]   m_r_pl,
  input  logic [N_MST-1:0]      m_awvalid,
  output logic [N_MST-1:0]      m_awready,
  input  logic [N_MST*49-1:0]   m_aw_pl,
  input  logic [N_MST-1:0]      m_wvalid,
  output logic [N_MST-1:0]      m_wready,
  input  logic [N_MST*37-1:0]   m_w_pl,
  output logic [N_MST-1:0]      m_bvalid,
  input  logic [N_MST-1:0]      m_bready,
  output logic [N_MST*6-1:0]    m_b_pl,
  output logic                  io_arvalid,
  input  logic                  io_arready,
  output logic [48:0]           io_ar_pl,
  input  logic                  io_rvalid,
  output logic                  io_rready,
  input  logic [38:0]           io_r_pl,
  output logic                  io_awvalid,
  input  logic                  io_awready,
  output logic [48:0]           io_aw_pl,
  output logic                  io_wvalid,
  input  logic                  io_wready,
  output logic [36:0]           io_w_pl,
  input  logic                  io_bvalid,
  output logic                  io_bready,
  input  logic [5:0]            io_b_pl,
  output logic                  l_arvalid,
  input  logic                  l_arready,
  output logic [48:0]           l_ar_pl,
  input  logic                  l_rvalid,
  output logic                  l_rready,
  input  logic [38:0]           l_r_pl,
  output logic [N_MST-1:0]      grant,
  output logic                  err_timeout
);

  localparam int unsigned AX_W   = 49;
  localparam int unsigned R_W    = 39;
  localparam int unsigned W_W    = 37;
  localparam int unsigned B_W    = 6;
  localparam int unsigned IW     = (N_MST > 1) ? $clog2(N_MST) : 1;
  localparam logic [31:0] WD_LIM = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  state_t          state, state_nx;
  logic [IW-1:0]   gnt_idx, rr_ptr, win_idx;
  logic            win_found, win_wr, win_local;
  logic            sel_local, addr_done, err_q;
  logic [31:0]     wdog;
  logic [N_MST-1:0] req;

  // granted master's upstream-driven signals
  logic            g_arvalid, g_rready, g_awvalid, g_wvalid, g_bready;
  logic [AX_W-1:0] g_ar_pl, g_aw_pl;
  logic [W_W-1:0]  g_w_pl;

  // selected target's response-side signals (0 outside RD/WR)
  logic            t_arready, t_rvalid, t_awready, t_wready, t_bvalid;
  logic [R_W-1:0]  t_r_pl;
  logic [B_W-1:0]  t_b_pl;

  logic addr_hs, data_hs, rd_done, wr_done;

  assign req = m_arvalid | m_awvalid;

  // Round-robin pick: first requester at or after rr_ptr, wrapping upward.
  always_comb begin
    int unsigned j;
    j         = 0;
    win_found = 1'b0;
    win_idx   = '0;
    win_wr    = 1'b0;
    win_local = 1'b0;
    for (int unsigned k = 0; k < N_MST; k++) begin
      j = 32'(rr_ptr) + k;
      if (j >= N_MST) j = j - N_MST;
      if (!win_found && req[j]) begin
        win_found = 1'b1;
        win_idx   = IW'(j);
        win_wr    = m_awvalid[j];
        win_local = (m_ar_pl[j*AX_W + 33 +: 16] == LOCAL_BASE);
      end
    end
  end

  // Mux the owner's request-side signals.
  always_comb begin
    g_arvalid = 1'b0;
    g_ar_pl   = '0;
    g_rready  = 1'b0;
    g_awvalid = 1'b0;
    g_aw_pl   = '0;
    g_wvalid  = 1'b0;
    g_w_pl    = '0;
    g_bready  = 1'b0;
    for (int unsigned i = 0; i < N_MST; i++) begin
      if (gnt_idx == IW'(i)) begin
        g_arvalid = m_arvalid[i];
        g_ar_pl   = m_ar_pl[i*AX_W +: AX_W];
        g_rready  = m_rready[i];
        g_awvalid = m_awvalid[i];
        g_aw_pl   = m_aw_pl[i*AX_W +: AX_W];
        g_wvalid  = m_wvalid[i];
        g_w_pl    = m_w_pl[i*W_W +: W_W];
        g_bready  = m_bready[i];
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (win_found) state_nx = win_wr ? WR : RD;
      RD:   if (rd_done)   state_nx = IDLE;
      WR:   if (wr_done)   state_nx = IDLE;
      default:             state_nx = IDLE;
    endcase
  end

  // Output routing. The address phase is forwarded only once per grant
  // (addr_done) so a master re-raising arvalid/awvalid inside its own
  // grant waits for a fresh arbitration instead of sneaking in a second
  // transaction.
  always_comb begin
    io_arvalid = 1'b0;
    io_ar_pl   = '0;
    io_rready  = 1'b0;
    io_awvalid = 1'b0;
    io_aw_pl   = '0;
    io_wvalid  = 1'b0;
    io_w_pl    = '0;
    io_bready  = 1'b0;
    l_arvalid  = 1'b0;
    l_ar_pl    = '0;
    l_rready   = 1'b0;
    t_arready  = 1'b0;
    t_rvalid   = 1'b0;
    t_r_pl     = '0;
    t_awready  = 1'b0;
    t_wready   = 1'b0;
    t_bvalid   = 1'b0;
    t_b_pl     = '0;
    m_arready  = '0;
    m_rvalid   = '0;
    m_r_pl     = '0;
    m_awready  = '0;
    m_wready   = '0;
    m_bvalid   = '0;
    m_b_pl     = '0;
    unique case (state)
      RD: begin
        if (sel_local) begin
          l_arvalid = g_arvalid & ~addr_done;
          l_ar_pl   = g_ar_pl;
          l_rready  = g_rready;
          t_arready = l_arready;
          t_rvalid  = l_rvalid;
          t_r_pl    = l_r_pl;
        end else begin
          io_arvalid = g_arvalid & ~addr_done;
          io_ar_pl   = g_ar_pl;
          io_rready  = g_rready;
          t_arready  = io_arready;
          t_rvalid   = io_rvalid;
          t_r_pl     = io_r_pl;
        end
      end
      WR: begin
        io_awvalid = g_awvalid & ~addr_done;
        io_aw_pl   = g_aw_pl;
        io_wvalid  = g_wvalid;
        io_w_pl    = g_w_pl;
        io_bready  = g_bready;
        t_awready  = io_awready;
        t_wready   = io_wready;
        t_bvalid   = io_bvalid;
        t_b_pl     = io_b_pl;
      end
      default: ;
    endcase
    for (int unsigned i = 0; i < N_MST; i++) begin
      if (state != IDLE && gnt_idx == IW'(i)) begin
        m_arready[i]            = t_arready & ~addr_done;
        m_rvalid[i]             = t_rvalid;
        m_r_pl[i*R_W +: R_W]    = t_r_pl;
        m_awready[i]            = t_awready & ~addr_done;
        m_wready[i]             = t_wready;
        m_bvalid[i]             = t_bvalid;
        m_b_pl[i*B_W +: B_W]    = t_b_pl;
      end
    end
  end

  assign addr_hs = ((g_arvalid & t_arready) | (g_awvalid & t_awready)) & ~addr_done;
  assign data_hs = (t_rvalid & g_rready) | (t_wready & g_wvalid) | (t_bvalid & g_bready);
  assign rd_done = (state == RD) & t_rvalid & g_rready & t_r_pl[4];
  assign wr_done = (state == WR) & t_bvalid & g_bready;

  always_comb begin
    grant = '0;
    if (state != IDLE) grant[gnt_idx] = 1'b1;
  end

  assign err_timeout = err_q;

  // Grant bookkeeping, round-robin pointer and watchdog
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_idx   <= '0;
      rr_ptr    <= '0;
      sel_local <= 1'b0;
      addr_done <= 1'b0;
      wdog      <= '0;
      err_q     <= 1'b0;
    end else if (state == IDLE) begin
      if (win_found) begin
        gnt_idx   <= win_idx;
        sel_local <= ~win_wr & win_local;
        addr_done <= 1'b0;
        wdog      <= '0;
      end
    end else begin
      if (addr_hs) addr_done <= 1'b1;
      if (rd_done || wr_done)
        rr_ptr <= (gnt_idx == IW'(N_MST - 1)) ? '0 : gnt_idx + 1'b1;
      // wdog saturates at the limit; the flag is raised on that stalled cycle
      if (TIMEOUT != 0 && !data_hs) begin
        if (wdog == WD_LIM) err_q <= 1'b1;
        else                wdog  <= wdog + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_25020037_axi_rr_arbiter.sv
module tb_ysyx_25020037_axi_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  m_arvalid, m_arready, m_rvalid, m_rready;
  logic [1:0]  m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [97:0] m_ar_pl, m_aw_pl;
  logic [77:0] m_r_pl;
  logic [73:0] m_w_pl;
  logic [11:0] m_b_pl;
  logic        io_arvalid, io_arready, io_rvalid, io_rready;
  logic        io_awvalid, io_awready, io_wvalid, io_wready, io_bvalid, io_bready;
  logic [48:0] io_ar_pl, io_aw_pl, l_ar_pl;
  logic [38:0] io_r_pl, l_r_pl;
  logic [36:0] io_w_pl;
  logic [5:0]  io_b_pl;
  logic        l_arvalid, l_arready, l_rvalid, l_rready;
  logic [1:0]  grant;
  logic        err_timeout;

  int checks = 0;
  int errors = 0;

  ysyx_25020037_axi_rr_arbiter #(
    .N_MST(2), .LOCAL_BASE(16'h0200), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst(rst),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_ar_pl(m_ar_pl),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_r_pl(m_r_pl),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_aw_pl(m_aw_pl),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_w_pl(m_w_pl),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_b_pl(m_b_pl),
    .io_arvalid(io_arvalid), .io_arready(io_arready), .io_ar_pl(io_ar_pl),
    .io_rvalid(io_rvalid), .io_rready(io_rready), .io_r_pl(io_r_pl),
    .io_awvalid(io_awvalid), .io_awready(io_awready), .io_aw_pl(io_aw_pl),
    .io_wvalid(io_wvalid), .io_wready(io_wready), .io_w_pl(io_w_pl),
    .io_bvalid(io_bvalid), .io_bready(io_bready), .io_b_pl(io_b_pl),
    .l_arvalid(l_arvalid), .l_arready(l_arready), .l_ar_pl(l_ar_pl),
    .l_rvalid(l_rvalid), .l_rready(l_rready), .l_r_pl(l_r_pl),
    .grant(grant), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          mst;
    bit          wr;
    logic [31:0] addr;
    bit          loc;
    logic [31:0] data;
  } vec_t;

  vec_t vecs[6];

  function automatic logic [48:0] ax(input logic [31:0] a, input logic [3:0] id,
                                     input logic [7:0] len);
    return {a, id, len, 3'd2, 2'd1};
  endfunction

  function automatic logic [38:0] rb(input logic [31:0] d, input logic last,
                                     input logic [3:0] id);
    return {d, 2'b00, last, id};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m_arvalid = '0; m_ar_pl = '0; m_rready = '0;
    m_awvalid = '0; m_aw_pl = '0; m_wvalid = '0; m_w_pl = '0; m_bready = '0;
    io_arready = 1'b0; io_rvalid = 1'b0; io_r_pl = '0;
    io_awready = 1'b0; io_wready = 1'b0; io_bvalid = 1'b0; io_b_pl = '0;
    l_arready = 1'b0; l_rvalid = 1'b0; l_r_pl = '0;
  endtask

  initial begin
    vec_t        t;
    logic [1:0]  g1;
    logic [48:0] apl;
    logic [38:0] rpl;
    logic [36:0] wpl;
    int          beat;
    int          beats_seen;

    vecs[0] = '{1, 1'b0, 32'h0200_BFF8, 1'b1, 32'hCAFE_0001};
    vecs[1] = '{1, 1'b1, 32'h0200_0000, 1'b0, 32'h1234_5678};
    vecs[2] = '{0, 1'b0, 32'h8000_0000, 1'b0, 32'hA5A5_0002};
    vecs[3] = '{0, 1'b1, 32'h8000_0010, 1'b0, 32'h0BAD_F00D};
    vecs[4] = '{0, 1'b0, 32'h0201_0000, 1'b0, 32'h7777_0004};
    vecs[5] = '{1, 1'b0, 32'h0200_0004, 1'b1, 32'h9999_0005};

    // ---- reset state (requests present must not leak through) ----
    rst = 1'b1;
    clear_inputs();
    m_arvalid = 2'b11;
    m_ar_pl   = {ax(32'h8000_0000, 4'd1, 8'd0), ax(32'h8000_0000, 4'd0, 8'd0)};
    tick(); tick();
    chk("rst_grant", grant, 2'b00);
    chk("rst_valids", {io_arvalid, io_awvalid, io_wvalid, l_arvalid}, 4'b0000);
    chk("rst_err", err_timeout, 1'b0);
    chk("rst_mready", {m_arready, m_awready}, 4'b0000);
    m_arvalid = '0;
    rst = 1'b0;
    tick();
    chk("idle_grant", grant, 2'b00);

    // ---- simultaneous reads: M0 first, M1 next despite M0 re-requesting ----
    m_arvalid = 2'b11;
    m_ar_pl   = {ax(32'h8000_0000, 4'd1, 8'd0), ax(32'h8000_0000, 4'd0, 8'd0)};
    io_arready = 1'b1;
    tick();
    chk("rr_first_grant", grant, 2'b01);
    chk("rr_first_arready", m_arready, 2'b01);
    chk("rr_first_arpl", io_ar_pl, ax(32'h8000_0000, 4'd0, 8'd0));
    tick();
    chk("rr_ar_once", io_arvalid, 1'b0);
    io_rvalid = 1'b1; io_r_pl = rb(32'h1111_1111, 1'b1, 4'd0); m_rready = 2'b11;
    #1;
    chk("rr_m0_rvalid", m_rvalid, 2'b01);
    chk("rr_m0_rdata", m_r_pl[38:0], rb(32'h1111_1111, 1'b1, 4'd0));
    tick();
    io_rvalid = 1'b0;
    chk("rr_bubble", grant, 2'b00);
    tick();
    chk("rr_second_grant", grant, 2'b10);
    chk("rr_second_arpl", io_ar_pl, ax(32'h8000_0000, 4'd1, 8'd0));
    tick();
    m_arvalid[1] = 1'b0;
    io_rvalid = 1'b1; io_r_pl = rb(32'h2222_2222, 1'b1, 4'd1);
    #1;
    chk("rr_m1_rvalid", m_rvalid, 2'b10);
    tick();
    io_rvalid = 1'b0;
    chk("rr_bubble2", grant, 2'b00);
    tick();
    chk("rr_third_grant", grant, 2'b01);
    tick();
    m_arvalid = '0;
    io_rvalid = 1'b1; io_r_pl = rb(32'h3333_3333, 1'b1, 4'd0);
    tick();
    clear_inputs();
    chk("rr_third_done", grant, 2'b00);

    // ---- table: single transactions, routing and payload pass-through ----
    for (int v = 0; v < 6; v++) begin
      t   = vecs[v];
      g1  = 2'b01 << t.mst;
      apl = ax(t.addr, 4'(v), 8'd0);
      if (!t.wr) begin
        m_arvalid[t.mst] = 1'b1;
        m_ar_pl[t.mst*49 +: 49] = apl;
        tick();
        chk("vec_rd_grant", grant, g1);
        chk("vec_rd_route", {l_arvalid, io_arvalid}, {t.loc, !t.loc});
        chk("vec_rd_arpl", t.loc ? l_ar_pl : io_ar_pl, apl);
        l_arready = 1'b1; io_arready = 1'b1;
        tick();
        clear_inputs();
        rpl = rb(t.data, 1'b1, 4'(t.mst));
        if (t.loc) begin
          l_rvalid = 1'b1; l_r_pl = rpl; io_r_pl = rb(32'hDEAD_BEEF, 1'b1, 4'd0);
        end else begin
          io_rvalid = 1'b1; io_r_pl = rpl; l_r_pl = rb(32'hDEAD_BEEF, 1'b1, 4'd0);
        end
        m_rready[t.mst] = 1'b1;
        #1;
        chk("vec_rd_rvalid", m_rvalid, g1);
        chk("vec_rd_rdata", m_r_pl[t.mst*39 +: 39], rpl);
        tick();
        clear_inputs();
        chk("vec_rd_done", grant, 2'b00);
      end else begin
        wpl = {t.data, 4'hF, 1'b1};
        m_awvalid[t.mst] = 1'b1;
        m_aw_pl[t.mst*49 +: 49] = apl;
        m_wvalid[t.mst] = 1'b1;
        m_w_pl[t.mst*37 +: 37] = wpl;
        tick();
        chk("vec_wr_grant", grant, g1);
        chk("vec_wr_route", {l_arvalid, io_awvalid}, 2'b01);
        chk("vec_wr_awpl", io_aw_pl, apl);
        chk("vec_wr_wpl", io_w_pl, wpl);
        io_awready = 1'b1; io_wready = 1'b1;
        tick();
        clear_inputs();
        io_bvalid = 1'b1; io_b_pl = {2'b01, 4'(t.mst)}; m_bready[t.mst] = 1'b1;
        #1;
        chk("vec_wr_bvalid", m_bvalid, g1);
        chk("vec_wr_bpl", m_b_pl[t.mst*6 +: 6], {2'b01, 4'(t.mst)});
        tick();
        clear_inputs();
        chk("vec_wr_done", grant, 2'b00);
      end
    end

    // ---- len=3 burst with toggling rready; M1 write held off ----
    m_arvalid[0] = 1'b1; m_ar_pl[48:0] = ax(32'h8000_0100, 4'd0, 8'd3);
    m_awvalid[1] = 1'b1; m_aw_pl[97:49] = ax(32'h8000_0200, 4'd1, 8'd0);
    m_wvalid[1]  = 1'b1; m_w_pl[73:37] = {32'h5555_0000, 4'hF, 1'b1};
    io_arready = 1'b1; io_awready = 1'b1; io_wready = 1'b1;
    tick();
    chk("burst_grant", grant, 2'b01);
    chk("burst_aw_hold", {m_awready, io_awvalid, io_wvalid}, 4'b0000);
    tick();
    m_arvalid[0] = 1'b0; io_arready = 1'b0;
    beat = 0;
    beats_seen = 0;
    for (int c = 0; c < 8; c++) begin
      m_rready[0] = (c % 2 == 1);
      io_rvalid = 1'b1;
      io_r_pl = rb(32'h1000 + beat, beat == 3, 4'd0);
      #1;
      if (c == 6) chk("burst_hold", grant, 2'b01);
      chk("burst_no_aw", {m_awready[1], io_awvalid}, 2'b00);
      if (m_rvalid[0] && m_rready[0]) begin
        beats_seen++;
        chk("burst_data", m_r_pl[38:0], rb(32'h1000 + beat, beat == 3, 4'd0));
      end
      if (m_rready[0]) beat++;
      tick();
    end
    io_rvalid = 1'b0; m_rready = '0;
    chk("burst_beats", beats_seen, 4);
    chk("burst_bubble", grant, 2'b00);
    tick();
    chk("burst_wr_grant", grant, 2'b10);
    chk("burst_wr_aw", io_awvalid, 1'b1);
    tick();
    m_awvalid[1] = 1'b0; m_wvalid[1] = 1'b0; io_awready = 1'b0; io_wready = 1'b0;
    io_bvalid = 1'b1; io_b_pl = 6'h01; m_bready[1] = 1'b1;
    #1;
    chk("burst_wr_b", m_bvalid, 2'b10);
    tick();
    clear_inputs();
    chk("burst_wr_done", grant, 2'b00);

    // ---- watchdog: stalled read, flag on 16th cycle after grant ----
    m_arvalid[0] = 1'b1; m_ar_pl[48:0] = ax(32'h8000_0300, 4'd0, 8'd0);
    io_arready = 1'b1;
    tick();
    chk("wd_grant", grant, 2'b01);
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (c == 1) begin
        m_arvalid[0] = 1'b0; io_arready = 1'b0;
      end
      if (c == 15) chk("wd_not_yet", err_timeout, 1'b0);
    end
    chk("wd_fired", err_timeout, 1'b1);
    chk("wd_still_granted", grant, 2'b01);
    io_rvalid = 1'b1; io_r_pl = rb(32'h4444_4444, 1'b1, 4'd0); m_rready[0] = 1'b1;
    #1;
    chk("wd_late_r", m_rvalid, 2'b01);
    tick();
    clear_inputs();
    chk("wd_done", grant, 2'b00);
    chk("wd_sticky", err_timeout, 1'b1);

    // ---- async reset during a write ----
    m_awvalid[1] = 1'b1; m_aw_pl[97:49] = ax(32'h8000_0400, 4'd1, 8'd0);
    m_wvalid[1]  = 1'b1; m_w_pl[73:37] = {32'h6666_0000, 4'hF, 1'b1};
    tick();
    chk("rstw_grant", grant, 2'b10);
    chk("rstw_wvalid", io_wvalid, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("rstw_async_w", {io_wvalid, io_awvalid}, 2'b00);
    chk("rstw_async_grant", grant, 2'b00);
    chk("rstw_err_clr", err_timeout, 1'b0);
    tick();
    rst = 1'b0;
    clear_inputs();
    m_arvalid = 2'b11;
    m_ar_pl   = {ax(32'h8000_0500, 4'd1, 8'd0), ax(32'h8000_0500, 4'd0, 8'd0)};
    tick();
    chk("rstw_rrptr", grant, 2'b01);
    io_arready = 1'b1;
    tick();
    m_arvalid = '0; io_arready = 1'b0;
    io_rvalid = 1'b1; io_r_pl = rb(32'h7777_7777, 1'b1, 4'd0); m_rready[0] = 1'b1;
    tick();
    clear_inputs();
    chk("rstw_done", grant, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
